seven_seg_mux: RTL and testbench
================================

Name: seven_seg_mux

Overview:
- Time-multiplexed driver for an N-digit multiplexed seven-segment display (shared a..g/dp lines, one enable per digit).
- Scans the digits at a fixed per-digit slot rate, with a configurable ghost-suppression blanking gap between digits.
- Supports optional leading-zero suppression and per-digit decimal points.
- Display data is double-buffered and swapped only at frame boundaries, so a frame never shows a mix of old and new data.
- Sits between application logic (counters, status values) and the board pins.

Parameters:
- NUM_DIGITS, 4: number of digits scanned; must be >= 1.
- SCAN_DIV, 16000: CLK cycles per digit slot (1 kHz slot rate at 16 MHz); must be >= 2.
- BLANK_CYCLES, 16: cycles at the start of each slot with all digits off; must be < SCAN_DIV.
- SEG_ACTIVE_LOW, 0: 1 inverts o_seg (common-anode segment drive).
- DIG_ACTIVE_LOW, 1: 1 means a digit enable is driven 0 to light it.
- LZ_SUPPRESS, 1: 1 enables leading-zero blanking.

Ports:
- CLK, input, 1: system clock.
- RST_N, input, 1: synchronous reset, active low.
- i_val, input, 4*NUM_DIGITS: hex nibbles; nibble d = i_val[4d+3:4d] drives digit d; digit 0 is least significant.
- i_dp, input, NUM_DIGITS: decimal point per digit.
- i_wr, input, 1: one-cycle strobe that captures i_val and i_dp into the pending buffer.
- i_blank, input, 1: level input; while high, all digit enables are inactive and scanning continues.
- o_seg, output, 8: {dp,g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW.
- o_dig, output, NUM_DIGITS: digit enables, polarity per DIG_ACTIVE_LOW.
- o_frame, output, 1: one-cycle pulse on the first output cycle of digit 0's slot.
- o_pending, output, 1: pending buffer holds data not yet displayed.

Behaviour:
- The design is one clock domain on CLK. RST_N is sampled on the CLK rising edge, active low, synchronous.
- Reset values:
  - slot counter sc = 0, digit index idx = 0.
  - Active and pending buffers = 0; o_pending = 0; o_frame = 0.
  - o_dig = all inactive; o_seg = all segments off (both at their polarity-correct inactive levels).
- Internal scan:
  - sc counts 0..SCAN_DIV-1.
  - When sc = SCAN_DIV-1, sc wraps to 0 and idx advances modulo NUM_DIGITS.
  - Frame period = NUM_DIGITS*SCAN_DIV cycles.
- Slot FSM (decoded from sc): BLANK while sc < BLANK_CYCLES, DRIVE otherwise. Transitions are BLANK->DRIVE at sc = BLANK_CYCLES and DRIVE->BLANK on slot wrap.
- All outputs are registered, with 1 cycle of latency from the internal sc/idx/state.
  - BLANK: o_dig all inactive; o_seg all off.
  - DRIVE: o_dig has only bit idx active; o_seg = decode(active nibble idx) with dp = active_dp[idx].
- Buffer swap:
  - Swap occurs on the internal cycle sc = 0, idx = 0 (frame start). If o_pending = 1 at that cycle, pending is copied to active and o_pending clears.
  - i_wr at any cycle: pending <= {i_val, i_dp}; o_pending <= 1. A later i_wr overwrites pending; last write wins.
  - i_wr on the frame-start cycle: the swap uses the old pending contents, the new data lands in pending, and o_pending stays 1.
- Leading-zero suppression (LZ_SUPPRESS = 1):
  - Digit d > 0 shows no a..g segments when active nibbles d..NUM_DIGITS-1 are all zero.
  - Digit 0 is never suppressed.
  - dp is still shown if set; the digit enable still follows the scan.
- i_blank is sampled every cycle and forces o_dig inactive on the next output cycle. It does not affect sc, idx, buffers or o_frame.
- Reset asserted mid-frame returns everything to reset values on the next edge. Pending data is lost.
- Widths:
  - sc is $clog2(SCAN_DIV) bits; idx is max(1,$clog2(NUM_DIGITS)) bits.
  - No arithmetic overflow is permitted; wraps are compare-based, not power-of-two reliant.

Decomposition:
- Shared package contains:
  - Segment bit positions (SEG_A..SEG_G, SEG_DP).
  - The 16-entry hex glyph constants in {g..a} order.
  - A slot-state enum {ST_BLANK, ST_DRIVE}.
- One sub-module: the existing hex_to_7seg decoder, instantiated once on the mux-selected nibble.
- Polarity inversion and leading-zero masking are applied after the decoder, inside seven_seg_mux.

Test Plan:
All scenarios use NUM_DIGITS = 4, SCAN_DIV = 8, BLANK_CYCLES = 2, DIG_ACTIVE_LOW = 1, SEG_ACTIVE_LOW = 0, LZ_SUPPRESS = 1.
- Reset: hold RST_N = 0 for 3 edges -> o_dig = 4'b1111, o_seg = 8'h00, o_pending = 0. After release -> o_frame pulses on the first output cycle, then every 32 cycles.
- Double buffering: pulse i_wr with i_val = 16'h1234 mid-frame.
  - Before the swap -> o_pending = 1 and the display is unchanged until the next o_frame.
  - After the swap -> o_pending = 0.
  - Digit 0 DRIVE -> o_seg = 8'h66 ('4'); digit 1 DRIVE -> o_seg = 8'h4F ('3').
- Slot shape: in each 8-cycle slot -> o_dig = 4'b1111 for 2 cycles, then one-hot-low (4'b1110, 4'b1101, 4'b1011, 4'b0111 in turn) for 6 cycles.
- Leading-zero suppression:
  - i_val = 16'h0050, i_dp = 4'b1000 -> digit 3 o_seg = 8'h80, digit 2 o_seg = 8'h00, digit 1 o_seg = 8'h6D, digit 0 o_seg = 8'h3F.
  - i_val = 0 -> only digit 0 shows 8'h3F.
- Write collision: i_wr(16'hAAAA) pending, then i_wr(16'h5555) on the frame-start cycle -> that frame shows AAAA, o_pending stays 1, and the next frame shows 5555.
- i_blank and reset mid-frame:
  - i_blank high for 10 cycles -> o_dig = 4'b1111 for those cycles; o_frame cadence is unchanged.
  - RST_N low mid-DRIVE -> outputs return to reset values on the next edge and pending is cleared.

Source files
------------

// File: rtl/seven_seg_mux_pkg.sv
// Shared constants for the multiplexed seven-segment driver: segment bit
// positions, hex glyphs in {g..a} order and the slot-state encoding.
package seven_seg_mux_pkg;

   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   // Entry n is the active-high {g,f,e,d,c,b,a} pattern for hex digit n.
   localparam logic [15:0][6:0] HEX_GLYPHS = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_DRIVE = 1'b1
   } slot_state_e;

endpackage

// File: rtl/seven_seg_mux_hex_to_7seg.sv
// Hex nibble to active-high {g..a} segment pattern; polarity and blanking
// are applied by the caller.
module hex_to_7seg
   import seven_seg_mux_pkg::*;
(
   input  logic [3:0] nib_i,
   output logic [6:0] seg_o
);

   assign seg_o = HEX_GLYPHS[nib_i];

endmodule

// File: rtl/seven_seg_mux.sv
// Time-multiplexed N-digit seven-segment driver with per-slot ghost blanking,
// leading-zero suppression and frame-aligned double buffering.
module seven_seg_mux
   import seven_seg_mux_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int SCAN_DIV       = 16000,
   parameter int BLANK_CYCLES   = 16,
   parameter int SEG_ACTIVE_LOW = 0,
   parameter int DIG_ACTIVE_LOW = 1,
   parameter int LZ_SUPPRESS    = 1
) (
   input  logic                      CLK,
   input  logic                      RST_N,
   input  logic [4*NUM_DIGITS-1:0]   i_val,
   input  logic [NUM_DIGITS-1:0]     i_dp,
   input  logic                      i_wr,
   input  logic                      i_blank,
   output logic [7:0]                o_seg,
   output logic [NUM_DIGITS-1:0]     o_dig,
   output logic                      o_frame,
   output logic                      o_pending
);

   localparam int SCW  = $clog2(SCAN_DIV);
   localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [SCW-1:0]        SC_LAST      = SCW'(SCAN_DIV - 1);
   localparam logic [SCW-1:0]        SC_BLANK_END = SCW'(BLANK_CYCLES);
   localparam logic [IDXW-1:0]       IDX_LAST     = IDXW'(NUM_DIGITS - 1);
   localparam logic [7:0]            SEG_OFF      = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
   localparam logic [NUM_DIGITS-1:0] DIG_OFF      = (DIG_ACTIVE_LOW != 0) ?
                                                    {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
   localparam slot_state_e           ST_RESET     = (BLANK_CYCLES > 0) ? ST_BLANK : ST_DRIVE;

   logic [SCW-1:0]          sc_q, sc_d;
   logic [IDXW-1:0]         idx_q, idx_d;
   slot_state_e             st_q, st_d;
   logic [4*NUM_DIGITS-1:0] act_val_q, act_val_d, pend_val_q, pend_val_d;
   logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
   logic                    pend_q, pend_d;
   logic [7:0]              seg_q, seg_d;
   logic [NUM_DIGITS-1:0]   dig_q, dig_d;
   logic                    frame_q, frame_d;

   logic                    frame_start_s;
   logic [3:0]              disp_nib_s;
   logic                    disp_dp_s;
   logic                    lz_s;
   logic [NUM_DIGITS-1:0]   dig_onehot_s;
   logic [NUM_DIGITS-1:0]   dig_act_s;
   logic [6:0]              glyph_s;
   logic [7:0]              seg_raw_s;

   // Slot counter / digit index advance; the slot state tracks the next sc value.
   always_comb begin
      frame_start_s = (sc_q == '0) && (idx_q == '0);
      if (sc_q == SC_LAST) begin
         sc_d = '0;
         if (idx_q == IDX_LAST) begin
            idx_d = '0;
         end else begin
            idx_d = idx_q + IDXW'(1);
         end
      end else begin
         sc_d  = sc_q + SCW'(1);
         idx_d = idx_q;
      end
      st_d = (sc_d < SC_BLANK_END) ? ST_BLANK : ST_DRIVE;
   end

   // Frame-start swap reads the old pending contents before a same-cycle write lands.
   always_comb begin
      pend_val_d = pend_val_q;
      pend_dp_d  = pend_dp_q;
      pend_d     = pend_q;
      if (frame_start_s && pend_q) begin
         act_val_d = pend_val_q;
         act_dp_d  = pend_dp_q;
         pend_d    = 1'b0;
      end else begin
         act_val_d = act_val_q;
         act_dp_d  = act_dp_q;
      end
      if (i_wr) begin
         pend_val_d = i_val;
         pend_dp_d  = i_dp;
         pend_d     = 1'b1;
      end else begin
         pend_d     = pend_d;
      end
   end

   // Digit select plus "this digit and everything above it is zero" scan.
   always_comb begin
      logic zero_above;
      zero_above   = 1'b1;
      disp_nib_s   = 4'h0;
      disp_dp_s    = 1'b0;
      lz_s         = 1'b0;
      dig_onehot_s = '0;
      for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
         zero_above = zero_above && (act_val_d[4*d +: 4] == 4'h0);
         if (idx_q == IDXW'(d)) begin
            disp_nib_s      = act_val_d[4*d +: 4];
            disp_dp_s       = act_dp_d[d];
            lz_s            = zero_above && (d != 0);
            dig_onehot_s[d] = 1'b1;
         end else begin
            dig_onehot_s[d] = 1'b0;
         end
      end
   end

   hex_to_7seg u_dec (
      .nib_i (disp_nib_s),
      .seg_o (glyph_s)
   );

   // Output next-state: blanking, leading-zero mask, then pin polarity.
   always_comb begin
      seg_raw_s = 8'h00;
      if (st_q == ST_DRIVE) begin
         seg_raw_s[SEG_DP] = disp_dp_s;
         if ((LZ_SUPPRESS != 0) && lz_s) begin
            seg_raw_s[SEG_G:SEG_A] = 7'h00;
         end else begin
            seg_raw_s[SEG_G:SEG_A] = glyph_s;
         end
         dig_act_s = dig_onehot_s;
      end else begin
         dig_act_s = '0;
      end
      if (i_blank) begin
         dig_act_s = '0;
      end else begin
         dig_act_s = dig_act_s;
      end
      seg_d   = seg_raw_s ^ SEG_OFF;
      dig_d   = dig_act_s ^ DIG_OFF;
      frame_d = frame_start_s;
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         sc_q       <= '0;
         idx_q      <= '0;
         st_q       <= ST_RESET;
         act_val_q  <= '0;
         act_dp_q   <= '0;
         pend_val_q <= '0;
         pend_dp_q  <= '0;
         pend_q     <= 1'b0;
         seg_q      <= SEG_OFF;
         dig_q      <= DIG_OFF;
         frame_q    <= 1'b0;
      end else begin
         sc_q       <= sc_d;
         idx_q      <= idx_d;
         st_q       <= st_d;
         act_val_q  <= act_val_d;
         act_dp_q   <= act_dp_d;
         pend_val_q <= pend_val_d;
         pend_dp_q  <= pend_dp_d;
         pend_q     <= pend_d;
         seg_q      <= seg_d;
         dig_q      <= dig_d;
         frame_q    <= frame_d;
      end
   end

   assign o_seg     = seg_q;
   assign o_dig     = dig_q;
   assign o_frame   = frame_q;
   assign o_pending = pend_q;

endmodule

// File: tb/tb_seven_seg_mux.sv
// Self-checking bench for seven_seg_mux (4 digits, 8-cycle slots, 2 blank cycles).
module tb_seven_seg_mux;

   localparam int ND = 4;
   localparam int SD = 8;
   localparam int BC = 2;
   localparam int FRAME = ND * SD;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic [15:0] i_val = 16'h0000;
   logic [3:0]  i_dp = 4'h0;
   logic        i_wr = 1'b0;
   logic        i_blank = 1'b0;
   logic [7:0]  o_seg;
   logic [3:0]  o_dig;
   logic        o_frame;
   logic        o_pending;

   int checks = 0;
   int errors = 0;

   // Reference model state: cycle count since reset plus the two buffers.
   int          tick = 0;
   logic [15:0] m_act_val = 16'h0, m_pend_val = 16'h0;
   logic [3:0]  m_act_dp = 4'h0, m_pend_dp = 4'h0;
   logic        m_pend = 1'b0;
   logic [7:0]  exp_seg = 8'h00;
   logic [3:0]  exp_dig = 4'hF;
   logic        exp_frame = 1'b0;

   logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   typedef struct {
      logic [15:0] val;
      logic [3:0]  dp;
      int          digit;
      logic [7:0]  seg;
   } vec_t;

   seven_seg_mux #(
      .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC),
      .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(1), .LZ_SUPPRESS(1)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .i_val(i_val), .i_dp(i_dp), .i_wr(i_wr),
      .i_blank(i_blank), .o_seg(o_seg), .o_dig(o_dig), .o_frame(o_frame),
      .o_pending(o_pending)
   );

   always #5 CLK = ~CLK;

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model(input logic rst, input logic wr, input logic blk,
                        input logic [15:0] val, input logic [3:0] dp);
      int pos, dg;
      logic [3:0] nib;
      if (!rst) begin
         tick = 0; m_act_val = 16'h0; m_act_dp = 4'h0; m_pend_val = 16'h0;
         m_pend_dp = 4'h0; m_pend = 1'b0;
         exp_seg = 8'h00; exp_dig = 4'hF; exp_frame = 1'b0;
      end else begin
         pos = tick % SD;
         dg  = (tick / SD) % ND;
         exp_frame = (pos == 0) && (dg == 0);
         if (exp_frame && m_pend) begin
            m_act_val = m_pend_val; m_act_dp = m_pend_dp; m_pend = 1'b0;
         end
         if (pos < BC) begin
            exp_dig = 4'hF;
            exp_seg = 8'h00;
         end else begin
            exp_dig = 4'hF & ~(4'b0001 << dg);
            nib = m_act_val[dg*4 +: 4];
            exp_seg = {m_act_dp[dg],
                       ((dg > 0) && ((m_act_val >> (dg*4)) == 16'h0)) ? 7'h00 : glyph[nib]};
         end
         if (blk) exp_dig = 4'hF;
         if (wr) begin
            m_pend_val = val; m_pend_dp = dp; m_pend = 1'b1;
         end
         tick++;
      end
   endtask

   task automatic step(input logic rst, input logic wr, input logic blk,
                       input logic [15:0] val, input logic [3:0] dp);
      @(negedge CLK);
      RST_N = rst; i_wr = wr; i_blank = blk; i_val = val; i_dp = dp;
      @(posedge CLK);
      model(rst, wr, blk, val, dp);
      #1;
      check8("seg", o_seg, exp_seg);
      check8("dig", {4'h0, o_dig}, {4'h0, exp_dig});
      check8("frame", {7'h0, o_frame}, {7'h0, exp_frame});
      check8("pending", {7'h0, o_pending}, {7'h0, m_pend});
   endtask

   task automatic idle();
      step(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
   endtask

   task automatic write(input logic [15:0] val, input logic [3:0] dp);
      step(1'b1, 1'b1, 1'b0, val, dp);
   endtask

   task automatic wait_frame();
      int n;
      n = 0;
      do begin
         idle();
         n++;
      end while (!o_frame && n < FRAME + 8);
      check8("frame_wait", {7'h0, o_frame}, 8'h01);
   endtask

   task automatic wait_digit(input int d);
      int n;
      logic [3:0] tgt;
      tgt = 4'hF & ~(4'b0001 << d);
      n = 0;
      do begin
         idle();
         n++;
      end while (o_dig !== tgt && n < FRAME + 8);
      check8("digit_wait", {4'h0, o_dig}, {4'h0, tgt});
   endtask

   initial begin
      vec_t vecs [10];
      int n;
      vecs[0] = '{16'h1234, 4'b0000, 0, 8'h66};
      vecs[1] = '{16'h1234, 4'b0000, 1, 8'h4F};
      vecs[2] = '{16'h0050, 4'b1000, 3, 8'h80};
      vecs[3] = '{16'h0050, 4'b1000, 2, 8'h00};
      vecs[4] = '{16'h0050, 4'b1000, 1, 8'h6D};
      vecs[5] = '{16'h0050, 4'b1000, 0, 8'h3F};
      vecs[6] = '{16'h0000, 4'b0000, 3, 8'h00};
      vecs[7] = '{16'h0000, 4'b0000, 1, 8'h00};
      vecs[8] = '{16'h0000, 4'b0000, 0, 8'h3F};
      vecs[9] = '{16'hC0DE, 4'b0001, 0, 8'hF9};

      // Reset held for three edges, then frame cadence.
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
         check8("rst_dig", {4'h0, o_dig}, 8'h0F);
         check8("rst_seg", o_seg, 8'h00);
         check8("rst_pending", {7'h0, o_pending}, 8'h00);
      end
      idle();
      check8("first_frame", {7'h0, o_frame}, 8'h01);
      n = 0;
      do begin
         idle();
         n++;
      end while (!o_frame && n < FRAME + 8);
      check8("frame_period", 8'(n), 8'(FRAME));

      // Double buffering with a mid-frame write.
      repeat (10) idle();
      write(16'h1234, 4'h0);
      check8("db_pending_set", {7'h0, o_pending}, 8'h01);
      wait_frame();
      check8("db_pending_clr", {7'h0, o_pending}, 8'h00);
      wait_digit(0);
      check8("db_d0", o_seg, 8'h66);
      wait_digit(1);
      check8("db_d1", o_seg, 8'h4F);

      // Slot shape over one whole frame.
      wait_frame();
      check8("shape_0", {4'h0, o_dig}, 8'h0F);
      for (int i = 1; i < FRAME; i++) begin
         idle();
         check8("shape", {4'h0, o_dig},
                {4'h0, ((i % SD) < BC) ? 4'hF : (4'hF & ~(4'b0001 << (i / SD)))});
      end

      // Table-driven display vectors.
      for (int v = 0; v < 10; v++) begin
         write(vecs[v].val, vecs[v].dp);
         wait_frame();
         wait_digit(vecs[v].digit);
         check8("vec_seg", o_seg, vecs[v].seg);
      end

      // Write collision on the frame-start cycle.
      write(16'hAAAA, 4'h0);
      n = 0;
      while ((tick % FRAME) != 0 && n < FRAME + 8) begin
         idle();
         n++;
      end
      write(16'h5555, 4'h0);
      check8("coll_frame", {7'h0, o_frame}, 8'h01);
      check8("coll_pending", {7'h0, o_pending}, 8'h01);
      wait_digit(0);
      check8("coll_old", o_seg, 8'h77);
      wait_frame();
      check8("coll_pending_clr", {7'h0, o_pending}, 8'h00);
      wait_digit(0);
      check8("coll_new", o_seg, 8'h6D);

      // i_blank for 10 cycles mid-scan.
      wait_digit(2);
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'b0, 1'b1, 16'h0, 4'h0);
         check8("blank_dig", {4'h0, o_dig}, 8'h0F);
      end

      // Reset mid-DRIVE drops pending data.
      write(16'h9999, 4'hF);
      wait_digit(1);
      step(1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
      check8("mid_rst_dig", {4'h0, o_dig}, 8'h0F);
      check8("mid_rst_seg", o_seg, 8'h00);
      check8("mid_rst_pending", {7'h0, o_pending}, 8'h00);
      check8("mid_rst_frame", {7'h0, o_frame}, 8'h00);
      wait_frame();
      wait_digit(0);
      check8("mid_rst_d0", o_seg, 8'h3F);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         step(1'b1, ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
              16'($urandom), 4'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

endmodule
